// File: rtl/mem_req_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mem_req_scheduler_pkg
// Shared definitions for the memory request scheduler:
//   - FSM state encoding
//   - memory tag values used for icache / dcache transactions
//   - requester indices used by the two-way arbiter
//   - default parameter values for the scheduler
//   - beat counter width helper
// ---------------------------------------------------------------------------
package mem_req_scheduler_pkg;

    localparam int ADDR_BITS_DEF = 28;
    localparam int DATA_BITS_DEF = 128;
    localparam int TAG_BITS_DEF  = 5;
    localparam int BEATS_DEF     = 4;

    // Tag carried on the memory command, echoed on every response beat.
    localparam int TAG_IC = 0;
    localparam int TAG_DC = 1;

    // Bit positions in the arbiter request/grant vectors.
    localparam int REQ_IC = 0;
    localparam int REQ_DC = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_e;

    // Beat counter width: enough for BEATS-1, never narrower than 2 bits.
    function automatic int cnt_bits(input int beats);
        int b;
        b = $clog2(beats);
        return (b < 2) ? 2 : b;
    endfunction

endpackage

// File: rtl/mem_req_scheduler_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a last-grant register.
// Ports:
//   clk      - clock
//   reset    - asynchronous active-high reset (last grant -> dcache)
//   req      - request vector, bit REQ_IC = icache, bit REQ_DC = dcache
//   advance  - record the current grant as the last grant this cycle
//   gnt      - one-hot grant (combinational), all-zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arb2
    import mem_req_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 when the dcache was the most recently granted requester.
    logic last_dc_q;
    logic last_dc_d;

    always_comb begin
        gnt       = 2'b00;
        last_dc_d = last_dc_q;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contention: hand the grant to whoever did not win last time.
            2'b11:   gnt = last_dc_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (advance && (gnt != 2'b00)) begin
            last_dc_d = gnt[REQ_DC];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dc_q <= 1'b1;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end

endmodule

// File: rtl/mem_req_scheduler.sv
// ---------------------------------------------------------------------------
// mem_req_scheduler
// Shares one tagged memory port between an icache (reads only) and a dcache
// (reads and writes). One transaction is in flight at a time:
//   IDLE  -> arbitrate, latch the winner's command
//   CMD   -> present command until mem_req_ready
//   WDATA -> pass BEATS dcache write beats through to memory
//   RDATA -> route BEATS tag-matching response beats to the owner
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   ic_req_*                        - icache read request (ready = accepted)
//   ic_resp_valid                   - current response beat is for icache
//   dc_req_* / dc_req_rw            - dcache request (1 = write)
//   dc_data_*                       - dcache write beats (bits + byte mask)
//   dc_resp_valid                   - current response beat is for dcache
//   mem_req_*                       - command to memory (rw, addr, tag)
//   mem_data_*                      - write beats to memory
//   mem_resp_valid / mem_resp_tag   - read response beats from memory
// A response beat whose tag does not match the transaction in flight is
// dropped and sets the sticky tag_err_q flag (cleared only by reset).
// ---------------------------------------------------------------------------
module mem_req_scheduler
    import mem_req_scheduler_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int TAG_BITS  = TAG_BITS_DEF,
    parameter int BEATS     = BEATS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    output logic                   ic_resp_valid,
    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic                   dc_req_rw,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_data_valid,
    output logic                   dc_data_ready,
    input  logic [DATA_BITS-1:0]   dc_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_data_mask,
    output logic                   dc_resp_valid,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic [TAG_BITS-1:0]    mem_req_tag,
    output logic                   mem_data_valid,
    input  logic                   mem_data_ready,
    output logic [DATA_BITS-1:0]   mem_data_bits,
    output logic [DATA_BITS/8-1:0] mem_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [TAG_BITS-1:0]    mem_resp_tag
);

    localparam int                  CNT_BITS  = cnt_bits(BEATS);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);
    localparam logic [TAG_BITS-1:0] TAG_IC_V  = TAG_BITS'(TAG_IC);
    localparam logic [TAG_BITS-1:0] TAG_DC_V  = TAG_BITS'(TAG_DC);

    state_e                state_q,   state_d;
    logic                  owner_q,   owner_d;   // 1 = dcache owns the transaction
    logic                  rw_q,      rw_d;
    logic [ADDR_BITS-1:0]  addr_q,    addr_d;
    logic [TAG_BITS-1:0]   tag_q,     tag_d;
    logic [CNT_BITS-1:0]   cnt_q,     cnt_d;
    logic                  tag_err_q, tag_err_d;

    logic [1:0] gnt;
    logic       arb_advance;
    logic       resp_match;
    logic       wr_beat;

    // Grants are only taken (and the last-grant register only moves) in IDLE,
    // which is what keeps a single transaction outstanding.
    assign arb_advance = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({dc_req_valid, ic_req_valid}),
        .advance (arb_advance),
        .gnt     (gnt)
    );

    assign resp_match = mem_resp_valid && (mem_resp_tag == tag_q);
    assign wr_beat    = dc_data_valid && mem_data_ready;

    // Command fields come straight from the latched registers so they cannot
    // move while the command waits for mem_req_ready.
    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_tag   = tag_q;
    assign mem_data_bits = dc_data_bits;
    assign mem_data_mask = dc_data_mask;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rw_d           = rw_q;
        addr_d         = addr_q;
        tag_d          = tag_q;
        cnt_d          = cnt_q;
        tag_err_d      = tag_err_q;
        mem_req_valid  = 1'b0;
        ic_req_ready   = 1'b0;
        dc_req_ready   = 1'b0;
        mem_data_valid = 1'b0;
        dc_data_ready  = 1'b0;
        ic_resp_valid  = 1'b0;
        dc_resp_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt != 2'b00) begin
                    owner_d = gnt[REQ_DC];
                    rw_d    = gnt[REQ_DC] & dc_req_rw;   // icache never writes
                    addr_d  = gnt[REQ_DC] ? dc_req_addr : ic_req_addr;
                    tag_d   = gnt[REQ_DC] ? TAG_DC_V : TAG_IC_V;
                    state_d = CMD;
                end
            end

            CMD: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    ic_req_ready = !owner_q;
                    dc_req_ready = owner_q;
                    cnt_d        = '0;
                    state_d      = rw_q ? WDATA : RDATA;
                end
            end

            WDATA: begin
                mem_data_valid = dc_data_valid;
                dc_data_ready  = mem_data_ready;
                if (wr_beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end

            RDATA: begin
                if (resp_match) begin
                    ic_resp_valid = !owner_q;
                    dc_resp_valid = owner_q;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end else if (mem_resp_valid) begin
                    tag_err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            tag_err_q <= tag_err_d;
        end
    end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mem_req_scheduler
// Directed scenarios followed by randomized transactions. Expected behaviour
// comes from a transaction-level model: round-robin winner choice, the
// command a winner should produce, BEATS beats per transaction, routing of
// response beats by tag, and a sticky tag-error flag.
// ---------------------------------------------------------------------------
module tb_mem_req_scheduler;
    import mem_req_scheduler_pkg::*;

    localparam int AB = 28;
    localparam int DB = 128;
    localparam int TB = 5;
    localparam int NB = 4;
    localparam int MB = DB / 8;

    typedef logic [127:0] v_t;

    logic          clk;
    logic          reset;
    logic          ic_req_valid;
    logic          ic_req_ready;
    logic [AB-1:0] ic_req_addr;
    logic          ic_resp_valid;
    logic          dc_req_valid;
    logic          dc_req_ready;
    logic          dc_req_rw;
    logic [AB-1:0] dc_req_addr;
    logic          dc_data_valid;
    logic          dc_data_ready;
    logic [DB-1:0] dc_data_bits;
    logic [MB-1:0] dc_data_mask;
    logic          dc_resp_valid;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [AB-1:0] mem_req_addr;
    logic [TB-1:0] mem_req_tag;
    logic          mem_data_valid;
    logic          mem_data_ready;
    logic [DB-1:0] mem_data_bits;
    logic [MB-1:0] mem_data_mask;
    logic          mem_resp_valid;
    logic [TB-1:0] mem_resp_tag;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit model_last_dc;   // last granted requester was the dcache
    bit model_err;       // sticky tag error expected

    mem_req_scheduler #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .TAG_BITS  (TB),
        .BEATS     (NB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ic_req_valid   (ic_req_valid),
        .ic_req_ready   (ic_req_ready),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_rw      (dc_req_rw),
        .dc_req_addr    (dc_req_addr),
        .dc_data_valid  (dc_data_valid),
        .dc_data_ready  (dc_data_ready),
        .dc_data_bits   (dc_data_bits),
        .dc_data_mask   (dc_data_mask),
        .dc_resp_valid  (dc_resp_valid),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_tag    (mem_req_tag),
        .mem_data_valid (mem_data_valid),
        .mem_data_ready (mem_data_ready),
        .mem_data_bits  (mem_data_bits),
        .mem_data_mask  (mem_data_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_tag   (mem_resp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input v_t obs, input v_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: a lone requester wins; on contention the one that
    // did not win last time wins.
    function automatic bit pick_dc(input bit icv, input bit dcv);
        if (icv && dcv) return !model_last_dc;
        return dcv;
    endfunction

    // One complete transaction. Caller has the winner's request driven and
    // the DUT in IDLE. mode 1 = directed pattern, mode 0 = random handshakes.
    task automatic xact(input bit who_dc, input bit rw, input logic [AB-1:0] addr,
                        input int stall, input int mode, input bit inject);
        logic [TB-1:0] exp_tag;
        logic [TB-1:0] t;
        logic [DB-1:0] bits;
        logic [MB-1:0] mask;
        int  pulses;
        int  beats;
        int  cyc;
        bit  dv, mr, rv, match;
        exp_tag = who_dc ? TB'(TAG_DC) : TB'(TAG_IC);
        pulses  = 0;
        beats   = 0;
        cyc     = 0;
        model_last_dc = who_dc;

        #1;
        chk("idle_no_cmd", v_t'(mem_req_valid), v_t'(0));
        tick();

        for (int s = 0; s <= stall; s++) begin
            mem_req_ready = (s == stall);
            #1;
            chk("cmd_valid", v_t'(mem_req_valid), v_t'(1));
            chk("cmd_addr",  v_t'(mem_req_addr),  v_t'(addr));
            chk("cmd_tag",   v_t'(mem_req_tag),   v_t'(exp_tag));
            chk("cmd_rw",    v_t'(mem_req_rw),    v_t'(rw));
            chk("own_ready", v_t'(who_dc ? dc_req_ready : ic_req_ready), v_t'(s == stall));
            chk("other_ready", v_t'(who_dc ? ic_req_ready : dc_req_ready), v_t'(0));
            pulses += int'(ic_req_ready) + int'(dc_req_ready);
            tick();
        end
        chk("ready_pulses", v_t'(pulses), v_t'(1));
        if (who_dc) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
        mem_req_ready = 1'b0;

        if (rw) begin
            while (beats < NB && cyc < 64) begin
                dv   = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                mr   = (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
                bits = {$urandom(), $urandom(), $urandom(), $urandom()};
                mask = (mode == 1) ? '1 : MB'($urandom());
                dc_data_valid  = dv;
                mem_data_ready = mr;
                dc_data_bits   = bits;
                dc_data_mask   = mask;
                mem_resp_valid = 1'($urandom_range(0, 1));
                mem_resp_tag   = exp_tag;
                #1;
                chk("wr_valid",   v_t'(mem_data_valid), v_t'(dv));
                chk("wr_ready",   v_t'(dc_data_ready),  v_t'(mr));
                chk("wr_bits",    v_t'(mem_data_bits),  v_t'(bits));
                chk("wr_mask",    v_t'(mem_data_mask),  v_t'(mask));
                chk("wr_no_resp", v_t'({ic_resp_valid, dc_resp_valid}), v_t'(0));
                if (dv && mr) beats++;
                cyc++;
                tick();
            end
            chk("wr_beats", v_t'(beats), v_t'(NB));
        end else begin
            dc_data_valid  = 1'b1;
            mem_data_ready = 1'b1;
            while (beats < NB && cyc < 64) begin
                rv = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                t  = exp_tag;
                if (inject && cyc == 1) t = exp_tag ^ TB'(1);
                mem_resp_valid = rv;
                mem_resp_tag   = t;
                #1;
                match = rv && (t == exp_tag);
                chk("rd_ic_resp",  v_t'(ic_resp_valid), v_t'(match && !who_dc));
                chk("rd_dc_resp",  v_t'(dc_resp_valid), v_t'(match && who_dc));
                chk("rd_no_wdata", v_t'({mem_data_valid, dc_data_ready}), v_t'(0));
                if (rv && !match) model_err = 1'b1;
                if (match) beats++;
                cyc++;
                tick();
            end
            chk("rd_beats", v_t'(beats), v_t'(NB));
        end

        // Back in IDLE: nothing may leak through.
        mem_resp_valid = 1'b1;
        mem_resp_tag   = exp_tag;
        dc_data_valid  = 1'b1;
        mem_data_ready = 1'b1;
        #1;
        chk("idle_quiet", v_t'({ic_resp_valid, dc_resp_valid, mem_data_valid,
                               dc_data_ready, mem_req_valid}), v_t'(0));
        mem_resp_valid = 1'b0;
        dc_data_valid  = 1'b0;
        mem_data_ready = 1'b0;
        chk("tag_err", v_t'(dut.tag_err_q), v_t'(model_err));
        $display("txn who=%s rw=%0d addr=%0h stall=%0d beats=%0d tag_err=%0d",
                 who_dc ? "dc" : "ic", rw, addr, stall, beats, dut.tag_err_q);
    endtask

    initial begin
        bit            icv, dcv, drw, w;
        logic [AB-1:0] ia, da;

        // Reset with every input trying to provoke an output.
        reset          = 1'b1;
        ic_req_valid   = 1'b1;
        ic_req_addr    = AB'(28'h200);
        dc_req_valid   = 1'b1;
        dc_req_rw      = 1'b0;
        dc_req_addr    = AB'(28'h300);
        dc_data_valid  = 1'b1;
        dc_data_bits   = '0;
        dc_data_mask   = '0;
        mem_req_ready  = 1'b1;
        mem_data_ready = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_tag   = '0;
        #1;
        chk("rst_outputs", v_t'({ic_req_ready, ic_resp_valid, dc_req_ready, dc_data_ready,
                                dc_resp_valid, mem_req_valid, mem_data_valid}), v_t'(0));
        chk("rst_tag_err", v_t'(dut.tag_err_q), v_t'(0));
        chk("rst_addr",    v_t'(mem_req_addr), v_t'(0));
        tick();
        tick();
        dc_data_valid  = 1'b0;
        mem_data_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        model_last_dc  = 1'b1;
        model_err      = 1'b0;
        reset          = 1'b0;

        // Contention right after reset: icache first, dcache on IDLE re-entry.
        xact(1'b0, 1'b0, AB'(28'h200), 0, 1, 1'b0);
        xact(1'b1, 1'b0, AB'(28'h300), 0, 1, 1'b0);

        // Lone icache read of 0x40.
        ic_req_valid = 1'b1;
        ic_req_addr  = AB'(28'h40);
        xact(1'b0, 1'b0, AB'(28'h40), 0, 1, 1'b0);

        // Dcache write of 0x80, memory ready toggling 1,0,1,0.
        dc_req_valid = 1'b1;
        dc_req_rw    = 1'b1;
        dc_req_addr  = AB'(28'h80);
        xact(1'b1, 1'b1, AB'(28'h80), 0, 1, 1'b0);

        // Command held 5 cycles by mem_req_ready low.
        dc_req_valid = 1'b1;
        dc_req_rw    = 1'b0;
        dc_req_addr  = AB'(28'h123);
        xact(1'b1, 1'b0, AB'(28'h123), 5, 1, 1'b0);

        // Wrong-tag beat during an icache read.
        ic_req_valid = 1'b1;
        ic_req_addr  = AB'(28'h240);
        xact(1'b0, 1'b0, AB'(28'h240), 0, 1, 1'b1);

        // Reset after the second read beat.
        ic_req_valid = 1'b1;
        ic_req_addr  = AB'(28'h500);
        #1;
        tick();
        mem_req_ready = 1'b1;
        #1;
        tick();
        ic_req_valid  = 1'b0;
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = TB'(TAG_IC);
            #1;
            chk("pre_rst_beat", v_t'(ic_resp_valid), v_t'(1));
            tick();
        end
        reset          = 1'b1;
        ic_req_valid   = 1'b1;
        dc_req_valid   = 1'b1;
        mem_req_ready  = 1'b1;
        dc_data_valid  = 1'b1;
        mem_data_ready = 1'b1;
        #1;
        chk("midrst_outputs", v_t'({ic_req_ready, ic_resp_valid, dc_req_ready, dc_data_ready,
                                   dc_resp_valid, mem_req_valid, mem_data_valid}), v_t'(0));
        chk("midrst_tag_err", v_t'(dut.tag_err_q), v_t'(0));
        tick();
        chk("midrst_hold", v_t'({ic_resp_valid, mem_req_valid}), v_t'(0));
        dc_req_valid   = 1'b0;
        mem_req_ready  = 1'b0;
        dc_data_valid  = 1'b0;
        mem_data_ready = 1'b0;
        mem_resp_valid = 1'b0;
        model_last_dc  = 1'b1;
        model_err      = 1'b0;
        reset          = 1'b0;
        ic_req_addr    = AB'(28'h600);
        xact(1'b0, 1'b0, AB'(28'h600), 0, 1, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            icv = 1'($urandom_range(0, 1));
            dcv = icv ? 1'($urandom_range(0, 1)) : 1'b1;
            drw = 1'($urandom_range(0, 1));
            ia  = AB'($urandom());
            da  = AB'($urandom());
            ic_req_valid = icv;
            ic_req_addr  = ia;
            dc_req_valid = dcv;
            dc_req_rw    = drw;
            dc_req_addr  = da;
            while (icv || dcv) begin
                w = pick_dc(icv, dcv);
                xact(w, w ? drw : 1'b0, w ? da : ia, $urandom_range(0, 3), 0,
                     1'($urandom_range(0, 1)));
                if (w) dcv = 1'b0; else icv = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_req_scheduler.md
MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_BITS, 28, main-memory address width.
- DATA_BITS, 128, memory beat width.
- TAG_BITS, 5, memory tag width.
- BEATS, 4, beats per cache-line transfer.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, asynchronous active-high reset.
- ic_req_valid, in, 1, icache read request.
- ic_req_ready, out, 1, icache request accepted.
- ic_req_addr, in, ADDR_BITS, icache line address.
- ic_resp_valid, out, 1, response beat belongs to icache.
- dc_req_valid, in, 1, dcache request.
- dc_req_ready, out, 1, dcache request accepted.
- dc_req_rw, in, 1, 1 = write, 0 = read.
- dc_req_addr, in, ADDR_BITS, dcache line address.
- dc_data_valid, in, 1, dcache write beat valid.
- dc_data_ready, out, 1, dcache write beat accepted.
- dc_data_bits, in, DATA_BITS, write beat.
- dc_data_mask, in, DATA_BITS/8, byte mask.
- dc_resp_valid, out, 1, response beat belongs to dcache.
- mem_req_valid, out, 1, command valid.
- mem_req_ready, in, 1, memory accepts command.
- mem_req_rw, out, 1, command direction.
- mem_req_addr, out, ADDR_BITS, command address.
- mem_req_tag, out, TAG_BITS, command tag.
- mem_data_valid, out, 1, write beat valid.
- mem_data_ready, in, 1, memory accepts write beat.
- mem_data_bits, out, DATA_BITS, write beat.
- mem_data_mask, out, DATA_BITS/8, byte mask.
- mem_resp_valid, in, 1, read response beat.
- mem_resp_tag, in, TAG_BITS, tag of response beat.

Function
REQ-003 The FSM SHALL have four states: IDLE, CMD, WDATA, RDATA.
REQ-004 In IDLE, arbitration SHALL be combinational:
- If only one requester is valid, it is granted.
- If both are valid, the requester not granted last time is granted; after reset, dcache is treated as the last granted.
REQ-005 On a grant, the block SHALL latch requester ID, rw (icache forced 0) and address, then move to CMD the next cycle.
REQ-006 In CMD, the command outputs SHALL be as follows:
- mem_req_valid = 1, with latched rw and address.
- mem_req_tag = 0 for icache, 1 for dcache.
- All command outputs held stable until mem_req_ready.
REQ-007 The requester's *_req_ready SHALL pulse for exactly one cycle, on the cycle mem_req_valid and mem_req_ready are both high.
REQ-008 On command acceptance, the FSM SHALL go to WDATA if rw = 1, otherwise to RDATA.
REQ-009 In WDATA, write data SHALL pass through combinationally:
- mem_data_valid = dc_data_valid.
- dc_data_ready = mem_data_ready.
- bits and mask passed through unchanged.
REQ-010 A 2-bit-minimum beat counter SHALL count handshaked write beats; after BEATS beats the FSM SHALL return to IDLE, with no response expected.
REQ-011 In RDATA, each mem_resp_valid beat with mem_resp_tag equal to the latched tag SHALL assert the owner's *_resp_valid in the same cycle and increment the beat counter.
REQ-012 After beat BEATS-1, the FSM SHALL return to IDLE.
REQ-013 In RDATA, a response beat with a non-matching tag SHALL be dropped and SHALL set the sticky status bit tag_err, which is cleared only by reset.
REQ-014 Outside RDATA, ic_resp_valid and dc_resp_valid SHALL be 0 regardless of mem_resp_valid.
REQ-015 Outside WDATA, mem_data_valid and dc_data_ready SHALL be 0.
REQ-016 Only one memory transaction SHALL be outstanding at any time; a new grant occurs only in IDLE.
REQ-017 The beat counter SHALL clear on every entry to WDATA or RDATA; wrap past BEATS-1 is not permitted.
REQ-018 Minimum read latency SHALL be:
- grant to mem_req_valid: 1 cycle;
- IDLE re-entry to next grant: 0 cycles.

Reset
REQ-019 Reset SHALL force the following, asynchronously:
- state to IDLE;
- counter to 0;
- last-grant to dcache;
- tag_err to 0;
- latched address, rw and tag to 0.
REQ-020 While reset is high, all valid and ready outputs SHALL be 0.
REQ-021 Assertion of reset mid-transaction SHALL abandon the transaction without emitting any further beats.

Structure
REQ-022 The shared package SHALL hold:
- state encoding;
- tag constants TAG_IC = 0 and TAG_DC = 1;
- defaults for ADDR_BITS, DATA_BITS, TAG_BITS and BEATS.
REQ-023 The arbitration logic SHALL be a sub-module, rr_arb2 (two requesters, last-grant register, one-hot grant output).
REQ-024 The FSM, counter and muxing SHALL be implemented in the top module.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Icache read 0x40 alone, mem_req_ready high: mem_req_valid at cycle +1 with tag 0; 4 response beats tag 0 give 4 ic_resp_valid pulses; dc_resp_valid stays 0.
- Icache and dcache read valid in the same cycle after reset: icache granted first; dcache granted on the cycle IDLE is re-entered.
- Dcache write 0x80 with mem_data_ready toggling 1,0,1,0...: exactly 4 beats pass; mask 0xFFFF preserved; FSM returns to IDLE with no resp_valid.
- mem_req_ready low for 5 cycles: mem_req_addr and mem_req_tag stable; ready pulse occurs exactly once.
- Tag-1 beat injected during an icache read: beat dropped, tag_err = 1, and the counter still needs 4 tag-0 beats.
- Reset asserted after the 2nd read beat: outputs 0 immediately; the next request starts cleanly with counter 0.
